mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Parametrised muxed-D scan register with an on-chip scan sequencer. It replaces hand-driven SE/SIx stimulus with a handshaked pattern/response interface. The block holds the core's W = NCH×LEN state flops, split into NCH scan chains of LEN flops each, and sits between the combinational core logic and the test controller. In test mode it shifts a pattern in while unloading the previous capture, pulses one capture clock, and returns responses. Outside test mode it behaves as a plain state register.

## Interface
- NCH, 3: number of scan chains (≥1).
- LEN, 4: flops per chain (≥1); W = NCH*LEN.
- CK  in  1  clock, rising-edge.
- RSTN  in  1  asynchronous, active-low reset.
- D_FUNC  in  W  next-state from core logic.
- Q  out  W  register state to core logic; chain c = Q[c*LEN+LEN-1 : c*LEN].
- TEST_MODE  in  1  1 = sequencer active, 0 = functional.
- PAT  in  W  scan-in pattern (target Q value after shift).
- PAT_VALID / PAT_READY  in / out  1  pattern handshake.
- UNLOAD_REQ  in  1  request a flush-only unload (no capture).
- RESP  out  W  unloaded register contents.
- RESP_VALID / RESP_READY  out / in  1  response handshake.
- SE  out  1  scan enable (1 during shift).
- SO  out  NCH  serial out per chain; SO[c] = Q[c*LEN].
- BUSY  out  1  state ≠ IDLE.

## Operation
- Reset values: Q=0, RESP=0, RESP_VALID=0, SE=0, BUSY=0, state IDLE, have_capt=0.
- **TEST_MODE=0:** Q <= D_FUNC every edge. PAT_READY=0. The FSM is forced to IDLE.
- **FSM states:** IDLE, SHIFT, CAPTURE, UNLOAD.
- **PAT_READY:** equals (IDLE && TEST_MODE && !RESP_VALID).
- **IDLE:**
  - PAT_VALID&&PAT_READY: latch PAT into pat_sh, then go to SHIFT.
  - Otherwise UNLOAD_REQ && TEST_MODE && !RESP_VALID: pat_sh=0, then go to UNLOAD.
  - PAT_VALID has priority over UNLOAD_REQ.
  - In IDLE with TEST_MODE=1, Q holds its value.
- **Shift step (SHIFT/UNLOAD), per chain c, i in 0..LEN-2:**
  - Q[c*LEN+i] <= Q[c*LEN+i+1]
  - Q[c*LEN+LEN-1] <= pat_sh[c*LEN]
  - pat_sh shifts identically, filling with 0.
  - resp_sh chain c shifts identically, taking Q[c*LEN] at its top.
- **Shift completion:** after LEN steps, Q == latched PAT and resp_sh == Q before the shift.
- **Shift counter:** width clog2(LEN+1), loaded at entry, counts LEN steps.
- **SHIFT → CAPTURE** after the LEN-th step. CAPTURE is one edge with SE=0: Q <= D_FUNC, have_capt <= 1, then IDLE.
- **UNLOAD → IDLE** after the LEN-th step. There is no capture, Q ends at 0, and have_capt <= 0.
- **Response emission:**
  - At the last shift edge, if have_capt was 1 at shift entry: RESP <= resp_sh (final), RESP_VALID <= 1.
  - If have_capt was 0, no response is emitted.
  - have_capt is cleared at shift entry.
- **Response handshake:** RESP/RESP_VALID hold until RESP_VALID&&RESP_READY at an edge, which clears RESP_VALID.
- **TEST_MODE falls in SHIFT/CAPTURE/UNLOAD:**
  - Abort to IDLE on that edge; Q <= D_FUNC.
  - No response is emitted; have_capt <= 0. A pending RESP_VALID is kept.
- **Reset asserted mid-operation:** immediately returns every state and output to its reset value.

## Timing
- Pattern accepted at edge t: shift edges t+1..t+LEN, capture edge t+LEN+1, BUSY low from t+LEN+1.
- SE=1 in the cycles after edges t..t+LEN-1, i.e. exactly LEN cycles. SE is registered from state.
- RESP_VALID is high in the cycle after edge t+LEN.
- Back-to-back throughput is LEN+2 cycles per pattern, because IDLE lasts ≥1 cycle between patterns.
- UNLOAD: accepted at t, RESP_VALID after edge t+LEN, IDLE at t+LEN.
- SO is combinational from Q.

## Test plan
All scenarios use NCH=3, LEN=4.
- **Reset:** assert RSTN=0 during the 2nd shift cycle → Q=0, SE=0, BUSY=0, RESP_VALID=0 asynchronously. After release, PAT_READY=1 with TEST_MODE=1.
- **Functional mode:** TEST_MODE=0, D_FUNC=12'hA5C → Q=12'hA5C after one edge; PAT_READY=0, SE=0.
- **First pattern:** PAT=12'h3C9, D_FUNC=12'h0F0 → SE high exactly 4 cycles; Q=12'h3C9 after the 4th shift; Q=12'h0F0 after capture; RESP_VALID stays 0.
- **Second pattern:** PAT=12'hFFF with RESP_READY=0 →
  - SO[1]=1 for all 4 shift cycles; SO[0]=SO[2]=0.
  - RESP=12'h0F0 with RESP_VALID=1, held 5+ cycles.
  - PAT_READY=0 until RESP_READY=1 consumes the response.
- **Unload:** after capture of 12'h5A5, pulse UNLOAD_REQ → SE 4 cycles, RESP=12'h5A5, Q=0, no capture. A second UNLOAD_REQ yields no RESP_VALID.
- **Abort:** drop TEST_MODE during the 3rd shift cycle → IDLE, BUSY=0, Q=D_FUNC next edge, no RESP_VALID. The next pattern emits no response.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Muxed-D scan register holding NCH chains of LEN flops, with a sequencer that
// shifts patterns in, pulses one capture, and returns the unloaded responses.
module mux_scan_ctrl #(
  parameter int NCH = 3,
  parameter int LEN = 4
) (
  input  logic               CK,
  input  logic               RSTN,
  input  logic [NCH*LEN-1:0] D_FUNC,
  output logic [NCH*LEN-1:0] Q,
  input  logic               TEST_MODE,
  input  logic [NCH*LEN-1:0] PAT,
  input  logic               PAT_VALID,
  output logic               PAT_READY,
  input  logic               UNLOAD_REQ,
  output logic [NCH*LEN-1:0] RESP,
  output logic               RESP_VALID,
  input  logic               RESP_READY,
  output logic               SE,
  output logic [NCH-1:0]     SO,
  output logic               BUSY
);

  localparam int W     = NCH * LEN;
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, UNLOAD} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     pat_sh_q, pat_sh_d;
  logic [W-1:0]     resp_sh_q, resp_sh_d;
  logic [W-1:0]     resp_q, resp_d;
  logic [W-1:0]     q_shift, pat_shift, resp_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_capt_q, have_capt_d;
  logic             emit_q, emit_d;
  logic             resp_valid_q, resp_valid_d;
  logic             se_q, se_d;
  logic             pat_ready;

  // One shift step: every chain moves toward bit 0; the pattern enters at the
  // top of Q, and the bit leaving Q enters the top of the response chain.
  always_comb begin
    q_shift    = '0;
    pat_shift  = '0;
    resp_shift = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < LEN - 1; i++) begin
        q_shift[c*LEN+i]    = q_q[c*LEN+i+1];
        pat_shift[c*LEN+i]  = pat_sh_q[c*LEN+i+1];
        resp_shift[c*LEN+i] = resp_sh_q[c*LEN+i+1];
      end
      q_shift[c*LEN+LEN-1]    = pat_sh_q[c*LEN];
      pat_shift[c*LEN+LEN-1]  = 1'b0;
      resp_shift[c*LEN+LEN-1] = q_q[c*LEN];
    end
  end

  assign pat_ready = (state_q == IDLE) && TEST_MODE && !resp_valid_q;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    pat_sh_d     = pat_sh_q;
    resp_sh_d    = resp_sh_q;
    resp_d       = resp_q;
    cnt_d        = cnt_q;
    have_capt_d  = have_capt_q;
    emit_d       = emit_q;
    resp_valid_d = resp_valid_q;

    if (resp_valid_q && RESP_READY) resp_valid_d = 1'b0;

    if (!TEST_MODE) begin
      // Functional mode, or an abort out of an active sequence.
      q_d     = D_FUNC;
      state_d = IDLE;
      if (state_q != IDLE) have_capt_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PAT_VALID && pat_ready) begin
            pat_sh_d    = PAT;
            state_d     = SHIFT;
            cnt_d       = CNT_W'(LEN);
            emit_d      = have_capt_q;
            have_capt_d = 1'b0;
          end else if (UNLOAD_REQ && !resp_valid_q) begin
            pat_sh_d    = '0;
            state_d     = UNLOAD;
            cnt_d       = CNT_W'(LEN);
            emit_d      = have_capt_q;
            have_capt_d = 1'b0;
          end
        end
        SHIFT, UNLOAD: begin
          q_d       = q_shift;
          pat_sh_d  = pat_shift;
          resp_sh_d = resp_shift;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (emit_q) begin
              resp_d       = resp_shift;
              resp_valid_d = 1'b1;
            end
            state_d = (state_q == SHIFT) ? CAPTURE : IDLE;
          end
        end
        CAPTURE: begin
          q_d         = D_FUNC;
          have_capt_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    se_d = (state_d == SHIFT) || (state_d == UNLOAD);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      q_q          <= '0;
      pat_sh_q     <= '0;
      resp_sh_q    <= '0;
      resp_q       <= '0;
      cnt_q        <= '0;
      have_capt_q  <= 1'b0;
      emit_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      se_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      pat_sh_q     <= pat_sh_d;
      resp_sh_q    <= resp_sh_d;
      resp_q       <= resp_d;
      cnt_q        <= cnt_d;
      have_capt_q  <= have_capt_d;
      emit_q       <= emit_d;
      resp_valid_q <= resp_valid_d;
      se_q         <= se_d;
    end
  end

  always_comb begin
    SO = '0;
    for (int c = 0; c < NCH; c++) SO[c] = q_q[c*LEN];
  end

  assign Q          = q_q;
  assign RESP       = resp_q;
  assign RESP_VALID = resp_valid_q;
  assign SE         = se_q;
  assign BUSY       = (state_q != IDLE);
  assign PAT_READY  = pat_ready;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized and directed bench for mux_scan_ctrl (NCH=3, LEN=4), checked
// against a transaction-level model of register contents and response state.
module tb_mux_scan_ctrl;

  localparam int NCH = 3;
  localparam int LEN = 4;
  localparam int W   = NCH * LEN;

  logic           CK = 1'b0;
  logic           RSTN;
  logic [W-1:0]   D_FUNC, PAT, Q, RESP;
  logic           TEST_MODE, PAT_VALID, PAT_READY, UNLOAD_REQ;
  logic           RESP_VALID, RESP_READY, SE, BUSY;
  logic [NCH-1:0] SO;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: register contents, capture-pending flag.
  logic [W-1:0] m_q;
  logic         m_have;

  // Observation of one operation, indexed by cycles after the accept edge.
  logic [W-1:0]   q_log  [20];
  logic [NCH-1:0] so_log [20];
  logic           rv_log [20];
  int             se_cnt;
  int             obs_len;

  mux_scan_ctrl #(.NCH(NCH), .LEN(LEN)) dut (
    .CK(CK), .RSTN(RSTN), .D_FUNC(D_FUNC), .Q(Q), .TEST_MODE(TEST_MODE),
    .PAT(PAT), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
    .UNLOAD_REQ(UNLOAD_REQ), .RESP(RESP), .RESP_VALID(RESP_VALID),
    .RESP_READY(RESP_READY), .SE(SE), .SO(SO), .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected Q after k shift steps: each chain moves down k places with the
  // low k pattern bits of that chain entering from the top.
  function automatic logic [W-1:0] partial_q(input logic [W-1:0] old_q,
                                             input logic [W-1:0] pat, input int k);
    int res = 0;
    int mask = (1 << LEN) - 1;
    for (int c = 0; c < NCH; c++) begin
      int oc = (int'(old_q) >> (c * LEN)) & mask;
      int pc = (int'(pat) >> (c * LEN)) & mask;
      res |= (((oc >> k) | (pc << (LEN - k))) & mask) << (c * LEN);
    end
    return W'(res);
  endfunction

  // Drive one pattern (or unload) from a negedge and record outputs until idle.
  task automatic run_op(input bit unload, input logic [W-1:0] pat,
                        input logic [W-1:0] dfunc);
    D_FUNC = dfunc;
    PAT    = pat;
    if (unload) UNLOAD_REQ = 1'b1; else PAT_VALID = 1'b1;
    @(negedge CK);
    PAT_VALID  = 1'b0;
    UNLOAD_REQ = 1'b0;
    se_cnt  = 0;
    obs_len = -1;
    for (int k = 0; k < 20; k++) begin
      q_log[k]  = Q;
      so_log[k] = SO;
      rv_log[k] = RESP_VALID;
      if (SE) se_cnt++;
      if (!BUSY) begin
        obs_len = k;
        break;
      end
      @(negedge CK);
    end
  endtask

  task automatic consume();
    RESP_READY = 1'b1;
    @(negedge CK);
    RESP_READY = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({Q, RESP, RESP_VALID, SE, BUSY} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: Q=%h RESP=%h RV=%b SE=%b BUSY=%b, all must be 0",
               Q, RESP, RESP_VALID, SE, BUSY);
    end
    @(negedge CK);
    RSTN = 1'b1;
    TEST_MODE = 1'b1;
    #1;
    n_tests++;
    if (PAT_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pat_ready: got %b want 1", PAT_READY);
    end
    m_q = '0;
    m_have = 1'b0;
  endtask

  task automatic test_functional();
    @(negedge CK);
    TEST_MODE = 1'b0;
    D_FUNC = 12'hA5C;
    PAT_VALID = 1'b1;
    @(negedge CK);
    PAT_VALID = 1'b0;
    m_q = 12'hA5C;
    n_tests++;
    if (Q !== m_q || PAT_READY !== 1'b0 || SE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL functional: Q=%h RDY=%b SE=%b BUSY=%b want Q=%h RDY=0 SE=0 BUSY=0",
               Q, PAT_READY, SE, BUSY, m_q);
    end
    TEST_MODE = 1'b1;
  endtask

  task automatic test_first_pattern();
    run_op(1'b0, 12'h3C9, 12'h0F0);
    n_tests++;
    if (se_cnt !== LEN || obs_len !== LEN + 1) begin
      n_fail++;
      $display("FAIL first_timing: se_cnt=%0d busy_len=%0d want %0d/%0d",
               se_cnt, obs_len, LEN, LEN + 1);
    end
    n_tests++;
    if (q_log[2] !== partial_q(m_q, 12'h3C9, 2) || q_log[LEN] !== 12'h3C9) begin
      n_fail++;
      $display("FAIL first_shift: mid=%h end=%h want %h/%h",
               q_log[2], q_log[LEN], partial_q(m_q, 12'h3C9, 2), 12'h3C9);
    end
    n_tests++;
    if (Q !== 12'h0F0 || rv_log[LEN] !== 1'b0 || RESP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL first_capture: Q=%h RV=%b/%b want 0f0, RV 0",
               Q, rv_log[LEN], RESP_VALID);
    end
    m_q = 12'h0F0;
    m_have = 1'b1;
  endtask

  task automatic test_second_pattern();
    logic [W-1:0] old_q = m_q;
    RESP_READY = 1'b0;
    run_op(1'b0, 12'hFFF, 12'h123);
    for (int k = 0; k < LEN; k++) begin
      n_tests++;
      if (so_log[k] !== 3'b010) begin
        n_fail++;
        $display("FAIL second_so[%0d]: got %b want 010", k, so_log[k]);
      end
    end
    n_tests++;
    if (se_cnt !== LEN || obs_len !== LEN + 1 || rv_log[LEN] !== 1'b1) begin
      n_fail++;
      $display("FAIL second_timing: se_cnt=%0d busy_len=%0d rv=%b", se_cnt, obs_len,
               rv_log[LEN]);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (RESP_VALID !== 1'b1 || RESP !== old_q || PAT_READY !== 1'b0) begin
        n_fail++;
        $display("FAIL second_hold[%0d]: RV=%b RESP=%h RDY=%b want 1/%h/0",
                 k, RESP_VALID, RESP, PAT_READY, old_q);
      end
      @(negedge CK);
    end
    consume();
    n_tests++;
    if (RESP_VALID !== 1'b0 || PAT_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL second_consume: RV=%b RDY=%b want 0/1", RESP_VALID, PAT_READY);
    end
    m_q = 12'h123;
    m_have = 1'b1;
  endtask

  task automatic test_unload();
    run_op(1'b0, W'($urandom), 12'h5A5);
    n_tests++;
    if (RESP_VALID !== 1'b1 || RESP !== m_q) begin
      n_fail++;
      $display("FAIL unload_pre_resp: RV=%b RESP=%h want 1/%h", RESP_VALID, RESP, m_q);
    end
    consume();
    m_q = 12'h5A5;
    run_op(1'b1, '0, W'($urandom));
    n_tests++;
    if (se_cnt !== LEN || obs_len !== LEN || rv_log[LEN] !== 1'b1) begin
      n_fail++;
      $display("FAIL unload_timing: se_cnt=%0d busy_len=%0d rv=%b want %0d/%0d/1",
               se_cnt, obs_len, rv_log[LEN], LEN, LEN);
    end
    n_tests++;
    if (RESP !== 12'h5A5 || Q !== '0) begin
      n_fail++;
      $display("FAIL unload_data: RESP=%h Q=%h want 5a5/000", RESP, Q);
    end
    consume();
    m_q = '0;
    m_have = 1'b0;
    run_op(1'b1, '0, W'($urandom));
    n_tests++;
    if (obs_len !== LEN || rv_log[LEN] !== 1'b0 || RESP_VALID !== 1'b0 || Q !== '0) begin
      n_fail++;
      $display("FAIL unload_second: busy_len=%0d RV=%b Q=%h want %0d/0/000",
               obs_len, RESP_VALID, Q, LEN);
    end
  endtask

  task automatic test_abort();
    run_op(1'b0, W'($urandom), 12'h77E);
    if (RESP_VALID) consume();
    m_q = 12'h77E;
    PAT = W'($urandom);
    PAT_VALID = 1'b1;
    @(negedge CK);
    PAT_VALID = 1'b0;
    @(negedge CK);
    @(negedge CK);
    TEST_MODE = 1'b0;
    D_FUNC = 12'h9B6;
    @(negedge CK);
    n_tests++;
    if (BUSY !== 1'b0 || SE !== 1'b0 || Q !== 12'h9B6 || RESP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: BUSY=%b SE=%b Q=%h RV=%b want 0/0/9b6/0",
               BUSY, SE, Q, RESP_VALID);
    end
    TEST_MODE = 1'b1;
    m_q = 12'h9B6;
    m_have = 1'b0;
    run_op(1'b0, 12'h246, 12'h8C1);
    n_tests++;
    if (rv_log[LEN] !== 1'b0 || RESP_VALID !== 1'b0 || Q !== 12'h8C1 || obs_len !== LEN + 1) begin
      n_fail++;
      $display("FAIL abort_next: RV=%b/%b Q=%h busy_len=%0d want 0/0/8c1/%0d",
               rv_log[LEN], RESP_VALID, Q, obs_len, LEN + 1);
    end
    m_q = 12'h8C1;
    m_have = 1'b1;
  endtask

  task automatic test_reset_mid();
    PAT = 12'hC33;
    PAT_VALID = 1'b1;
    @(negedge CK);
    PAT_VALID = 1'b0;
    @(negedge CK);
    #2 RSTN = 1'b0;
    #1;
    n_tests++;
    if (Q !== '0 || SE !== 1'b0 || BUSY !== 1'b0 || RESP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: Q=%h SE=%b BUSY=%b RV=%b want all 0",
               Q, SE, BUSY, RESP_VALID);
    end
    @(negedge CK);
    RSTN = 1'b1;
    #1;
    n_tests++;
    if (PAT_READY !== 1'b1 || Q !== '0) begin
      n_fail++;
      $display("FAIL reset_release: RDY=%b Q=%h want 1/000", PAT_READY, Q);
    end
    m_q = '0;
    m_have = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic         unload = ($urandom_range(0, 3) == 0);
      logic [W-1:0] pat    = W'($urandom);
      logic [W-1:0] dfunc  = W'($urandom);
      logic [W-1:0] old_q  = m_q;
      logic         emit   = m_have;
      int           k      = $urandom_range(0, LEN - 1);
      if ($urandom_range(0, 4) == 0) begin
        TEST_MODE = 1'b0;
        D_FUNC = dfunc;
        @(negedge CK);
        TEST_MODE = 1'b1;
        m_q = dfunc;
        old_q = dfunc;
        dfunc = W'($urandom);
      end
      run_op(unload, pat, dfunc);
      m_q    = unload ? '0 : dfunc;
      m_have = !unload;
      n_tests++;
      if (obs_len !== (unload ? LEN : LEN + 1) || se_cnt !== LEN || Q !== m_q) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%0d: busy_len=%0d se=%0d Q=%h want Q=%h",
                 n, unload, obs_len, se_cnt, Q, m_q);
      end
      n_tests++;
      if (q_log[LEN] !== (unload ? '0 : pat) || q_log[k] !== partial_q(old_q, unload ? '0 : pat, k)) begin
        n_fail++;
        $display("FAIL rand_shift[%0d]: end=%h mid[%0d]=%h", n, q_log[LEN], k, q_log[k]);
      end
      for (int c = 0; c < NCH; c++) begin
        n_tests++;
        if (so_log[k][c] !== old_q[c*LEN+k]) begin
          n_fail++;
          $display("FAIL rand_so[%0d] c=%0d k=%0d: got %b want %b",
                   n, c, k, so_log[k][c], old_q[c*LEN+k]);
        end
      end
      n_tests++;
      if (RESP_VALID !== emit || (emit && RESP !== old_q)) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: RV=%b RESP=%h want RV=%b RESP=%h",
                 n, RESP_VALID, RESP, emit, old_q);
      end
      if (RESP_VALID) begin
        for (int d = $urandom_range(0, 3); d > 0; d--) @(negedge CK);
        consume();
        n_tests++;
        if (RESP_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_consume[%0d]: RV=%b want 0", n, RESP_VALID);
        end
      end
    end
  endtask

  initial begin
    RSTN = 1'b0;
    TEST_MODE = 1'b0;
    D_FUNC = '0;
    PAT = '0;
    PAT_VALID = 1'b0;
    UNLOAD_REQ = 1'b0;
    RESP_READY = 1'b0;
    @(negedge CK);
    @(negedge CK);
    test_reset();
    test_functional();
    test_first_pattern();
    test_second_pattern();
    test_unload();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
